seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider.sv | 139 +++++++++++++
 tb/tb_seq_divider.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: default widths and FSM states.
package seq_divider_pkg;

    localparam int DW_DEF = 26;
    localparam int QW_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Sequential unsigned divider: one radix-2 restoring step per clock, MSB first.
// Quotient saturates to QW bits (ovf), divide-by-zero finishes in one cycle (dbz).
// Optional build macro SEQ_DIVIDER_ROUND_EN: round the quotient to nearest
// (add 1 when 2*remainder >= divisor) before saturation; default is floor.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int QW = QW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [QW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          busy,
    output logic          ready,
    output logic          ovf,
    output logic          dbz
);

    localparam int          CW    = $clog2(DW + 1);
    localparam logic [DW:0] Q_MAX = {{(DW + 1 - QW){1'b0}}, {QW{1'b1}}};

    state_t        state, state_nx;
    logic [DW-1:0] dsr_q;      // latched divisor
    logic [DW-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
    logic [DW-1:0] rem_q;      // partial remainder
    logic [CW-1:0] cnt_q;      // completed restoring steps
    logic          dbz_q;      // operation was started with a zero divisor

    logic          do_load, do_step, do_finish;
    logic [DW:0]   trial;
    logic          trial_ge;
    logic [DW-1:0] rem_sub;
    logic          round_up;
    logic [DW:0]   q_round;
    logic          q_ovf;
    logic [QW-1:0] q_sat;

    // State register; reset is synchronous and wins over any start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: zero divisor skips the iteration entirely.
    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = (divisor == '0) ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == CW'(DW - 1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Control decode: start is only honoured in IDLE, so it is ignored while busy.
    always_comb begin
        do_load   = (state == S_IDLE) && start;
        do_step   = (state == S_CALC);
        do_finish = (state == S_DONE);
    end

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    // The subtraction result is < divisor, so DW bits are enough for it.
    always_comb begin
        trial    = {rem_q, quo_q[DW-1]};
        trial_ge = (trial >= {1'b0, dsr_q});
        rem_sub  = trial[DW-1:0] - dsr_q;
    end

    // Final quotient: optional round-to-nearest, then saturation to QW bits.
    always_comb begin
`ifdef SEQ_DIVIDER_ROUND_EN
        round_up = ({rem_q, 1'b0} >= {1'b0, dsr_q});
`else
        round_up = 1'b0;
`endif
        q_round = {1'b0, quo_q} + (DW + 1)'(round_up);
        q_ovf   = (q_round > Q_MAX);
        q_sat   = q_ovf ? {QW{1'b1}} : q_round[QW-1:0];
    end

    // Datapath and result registers; results change only in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            dsr_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (do_load) begin
                dsr_q <= divisor;
                quo_q <= dividend;
                rem_q <= '0;
                cnt_q <= '0;
                dbz_q <= (divisor == '0);
                busy  <= 1'b1;
            end
            if (do_step) begin
                rem_q <= trial_ge ? rem_sub : trial[DW-1:0];
                quo_q <= {quo_q[DW-2:0], trial_ge};
                cnt_q <= cnt_q + CW'(1);
            end
            if (do_finish) begin
                busy  <= 1'b0;
                ready <= 1'b1;
                if (dbz_q) begin
                    quotient  <= {QW{1'b1}};
                    remainder <= quo_q;   // untouched latched dividend
                    ovf       <= 1'b0;
                    dbz       <= 1'b1;
                end else begin
                    quotient  <= q_sat;
                    remainder <= rem_q;
                    ovf       <= q_ovf;
                    dbz       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider with a result scoreboard.
// Honours SEQ_DIVIDER_ROUND_EN when computing expected quotients.
module tb_seq_divider;

    localparam int DW = 26;
    localparam int QW = 16;
    localparam longint LAT = DW + 1;

    typedef struct {
        longint q;
        longint r;
        longint ovf;
        longint dbz;
        longint due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic [QW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          busy, ready, ovf, dbz;

    int     n_vec  = 0;
    int     n_miss = 0;
    longint cyc    = 0;
    exp_t   sb[$];

    seq_divider #(.DW(DW), .QW(QW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .ready     (ready),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input longint a, input longint b);
        exp_t e;
        longint qq;
        e.due = 0;
        if (b == 0) begin
            e.q = (64'd1 << QW) - 1; e.r = a; e.ovf = 0; e.dbz = 1;
        end else begin
            qq = a / b;
            e.r = a % b;
`ifdef SEQ_DIVIDER_ROUND_EN
            if (2 * e.r >= b) qq = qq + 1;
`endif
            e.dbz = 0;
            if (qq > (64'd1 << QW) - 1) begin
                e.q = (64'd1 << QW) - 1; e.ovf = 1;
            end else begin
                e.q = qq; e.ovf = 0;
            end
        end
        return e;
    endfunction

    // Scoreboard: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency",   cyc,       e.due);
                check("quotient",  quotient,  e.q);
                check("remainder", remainder, e.r);
                check("ovf",       ovf,       e.ovf);
                check("dbz",       dbz,       e.dbz);
            end
        end
    end

    // Called at a negedge; the following posedge is the start edge.
    task automatic issue(input longint a, input longint b, input bit expect_res);
        exp_t e;
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = DW'(b);
        if (expect_res) begin
            e = model(a, b);
            e.due = cyc + 1 + ((b == 0) ? 1 : LAT);
            sb.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = DW'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
        check("ready_seen", ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_ovf", ovf, 0);
        check("rst_dbz", dbz, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic division with latency and hold check
        issue(15925, 300, 1);
        check("busy_after_start", busy, 1);
        drain();
        repeat (3) @(negedge clk);
        check("hold_quotient", quotient, 53);
        check("hold_remainder", remainder, 25);
        check("idle_busy", busy, 0);

        // Truncation / rounding case
        issue(20, 8, 1);
        drain();

        // Saturation
        issue(67108863, 1, 1);
        drain();

        // Divide by zero
        issue(500, 0, 1);
        drain();

        // Ignored start during CALC, then reset abort
        issue(1000, 3, 0);
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = DW'(9); divisor = '0;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignored_start", busy, 1);
        check("no_ready_ignored", ready, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_ovf", ovf, 0);
        check("abort_dbz", dbz, 0);
        repeat (DW + 5) @(negedge clk);
        check("abort_ready", ready, 0);
        issue(100, 7, 1);
        drain();

        // Back-to-back issue in the cycle after ready
        issue(123456, 789, 1);
        wait_ready();
        issue(65535, 1, 1);
        wait_ready();
        issue(10, 0, 1);
        wait_ready();
        for (int k = 0; k < 4; k++) begin
            longint a, b;
            a = longint'($urandom) & ((64'd1 << DW) - 1);
            b = longint'($urandom_range(1, 5000));
            issue(a, b, 1);
            wait_ready();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
